// File: rtl/adder_tree_bias.sv
// Pipelined signed adder tree with a per-vector bias, saturation and optional ReLU.
// log2(N_IN) pairwise-add stages feed one bias/saturate stage; a single stall enable covers all.
module adder_tree_bias #(
  parameter int unsigned N_IN = 8,
  parameter int unsigned DW   = 16,
  parameter int unsigned BW   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_IN*DW-1:0] din,
  input  logic [2:0]         bias_sel,
  input  logic               relu_en,
  input  logic               bias_we,
  input  logic [2:0]         bias_waddr,
  input  logic [BW-1:0]      bias_wdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      dout,
  output logic               sat
);

  localparam int unsigned L  = $clog2(N_IN);
  localparam int unsigned SW = DW + L;
  localparam int unsigned FW = SW + 1;

  // Bit offset of tree level s inside the flat lvl bus (level 0 is din).
  function automatic int unsigned lvl_off(input int unsigned s);
    int unsigned off;
    off = 0;
    for (int unsigned j = 0; j < s; j++) begin
      off += (N_IN >> j) * (DW + j);
    end
    return off;
  endfunction

  localparam int unsigned TOFF  = lvl_off(L);
  localparam int unsigned LVL_W = TOFF + SW;

  logic [LVL_W-1:0] lvl;
  logic [BW-1:0]    bias_tab [8];
  logic [L:1]       vld_q;
  logic [L:1]       relu_q;
  logic [BW-1:0]    bias_q [L:1];
  logic [SW-1:0]    tsum;
  logic [FW-1:0]    full;
  logic [DW-1:0]    res;
  logic             res_sat;

  assign in_ready       = !out_valid || out_ready;
  assign lvl[N_IN*DW-1:0] = din;

  always_ff @(posedge clk) begin
    if (rst) begin
      bias_tab[0] <= BW'(8'h17);
      bias_tab[1] <= BW'(8'h1B);
      bias_tab[2] <= BW'(8'h0A);
      bias_tab[3] <= BW'(8'h1F);
      bias_tab[4] <= BW'(8'h14);
      bias_tab[5] <= BW'(8'h17);
      bias_tab[6] <= BW'(8'h23);
      bias_tab[7] <= BW'(8'h06);
    end else if (bias_we) begin
      bias_tab[bias_waddr] <= bias_wdata;
    end
  end

  for (genvar s = 1; s <= L; s++) begin : g_stage
    localparam int unsigned IW   = DW + s - 1;
    localparam int unsigned OW   = DW + s;
    localparam int unsigned M    = N_IN >> s;
    localparam int unsigned IOFF = lvl_off(s - 1);
    localparam int unsigned OOFF = lvl_off(s);

    logic [M*OW-1:0] sum_d;
    logic [M*OW-1:0] sum_q;

    always_comb begin
      logic [IW-1:0] a;
      logic [IW-1:0] b;
      sum_d = '0;
      a     = '0;
      b     = '0;
      for (int unsigned k = 0; k < M; k++) begin
        a = lvl[IOFF + 2*k*IW +: IW];
        b = lvl[IOFF + (2*k+1)*IW +: IW];
        sum_d[k*OW +: OW] = {a[IW-1], a} + {b[IW-1], b};
      end
    end

    always_ff @(posedge clk) begin
      if (in_ready) begin
        sum_q <= sum_d;
      end
    end

    assign lvl[OOFF +: M*OW] = sum_q;
  end

  // Side-band: bias value is read at acceptance and travels with its vector.
  always_ff @(posedge clk) begin
    if (in_ready) begin
      relu_q[1] <= relu_en;
      bias_q[1] <= bias_tab[bias_sel];
      for (int unsigned s = 2; s <= L; s++) begin
        relu_q[s] <= relu_q[s-1];
        bias_q[s] <= bias_q[s-1];
      end
    end
  end

  assign tsum = lvl[TOFF +: SW];

  always_comb begin
    full    = {tsum[SW-1], tsum} + {{(FW-BW){bias_q[L][BW-1]}}, bias_q[L]};
    res     = full[DW-1:0];
    res_sat = 1'b0;
    // Out of range when the bits above the DW sign bit are not a pure sign extension.
    if (full[FW-1:DW-1] != '0 && full[FW-1:DW-1] != '1) begin
      res_sat = 1'b1;
      res     = full[FW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
    if (relu_q[L] && res[DW-1]) begin
      res     = '0;
      res_sat = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
      sat       <= 1'b0;
    end else if (in_ready) begin
      vld_q[1] <= in_valid;
      for (int unsigned s = 2; s <= L; s++) begin
        vld_q[s] <= vld_q[s-1];
      end
      out_valid <= vld_q[L];
      dout      <= res;
      sat       <= res_sat;
    end
  end

endmodule

// File: doc/adder_tree_bias.md
ADDER_TREE_BIAS -- requirements
Module: adder_tree_bias

Interface
REQ-001 Parameter N_IN, default 8, number of signed inputs; power of two, 2..16.
REQ-002 Parameter DW, default 16, input/output data width.
REQ-003 Parameter BW, default 8, bias width; bias table depth fixed at 8 entries.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  din/bias_sel/relu_en valid this cycle.
REQ-007 in_ready  out  1  block accepts input this cycle.
REQ-008 din  in  N_IN*DW  packed signed inputs, element k at bits [k*DW +: DW].
REQ-009 bias_sel  in  3  bias table index for this input vector.
REQ-010 relu_en  in  1  apply ReLU to this vector's result.
REQ-011 bias_we  in  1  bias table write strobe.
REQ-012 bias_waddr  in  3  bias table write index.
REQ-013 bias_wdata  in  BW  signed bias write data.
REQ-014 out_valid  out  1  dout valid.
REQ-015 out_ready  in  1  downstream accepts dout.
REQ-016 dout  out  DW  signed result.
REQ-017 sat  out  1  dout was clipped by saturation (qualified by out_valid).

Function
REQ-018 Pipeline SHALL have L = log2(N_IN) adder stages plus one bias/saturate/ReLU stage; latency L+1 cycles from accepted input to out_valid when never stalled (8 inputs -> 4 cycles).
REQ-019 Each adder stage SHALL sum adjacent pairs of the previous stage, growing width by 1 bit per stage, no truncation (stage-L width DW+L).
REQ-020 Final stage SHALL compute sum + sign-extended bias[bias_sel] at width DW+L+1, then saturate to signed DW range [-2^(DW-1), 2^(DW-1)-1], setting sat=1 when clipped.
REQ-021 When relu_en=1 for the vector, negative saturated results SHALL become 0 with sat=0; positive results unchanged; relu_en=0 passes signed value.
REQ-022 bias_sel and relu_en SHALL be captured with the vector at acceptance and travel with it; bias value SHALL be read at acceptance.
REQ-023 Handshake: input accepted when in_valid & in_ready; output consumed when out_valid & out_ready.
REQ-024 in_ready SHALL equal !out_valid | out_ready; when in_ready=0 all pipeline stages, valid bits and side-band hold.
REQ-025 Each stage SHALL carry a valid bit; bubbles propagate; no data loss or duplication under any out_ready pattern.
REQ-026 dout and sat SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 Bias write SHALL take effect the cycle after bias_we; a vector accepted in the same cycle as a write to its entry uses the old value.
REQ-028 Bias writes SHALL be accepted regardless of in_ready/stall state.

Reset
REQ-029 rst=1 at a rising edge SHALL clear all stage valid bits, out_valid=0, dout=0, sat=0; in-flight vectors discarded.
REQ-030 rst SHALL load bias table entries 0..7 with 0x17, 0x1B, 0x0A, 0x1F, 0x14, 0x17, 0x23, 0x06.
REQ-031 in_ready SHALL be 1 in the first cycle after reset release; inputs presented during rst are ignored.

Verification
REQ-032 Defaults, out_ready=1: din all 1, bias_sel=0, relu_en=0 -> dout=8+23=31, sat=0, out_valid exactly 4 cycles after acceptance.
REQ-033 din all 0x7FFF, bias_sel=6 -> dout=0x7FFF, sat=1; din all 0x8000, bias_sel=7, relu_en=0 -> dout=0x8000, sat=1; same with relu_en=1 -> dout=0, sat=0.
REQ-034 din all -10, bias_sel=2, relu_en=0 -> dout=-70; relu_en=1 -> dout=0.
REQ-035 Back-to-back 20 random vectors, out_ready randomly toggled -> outputs match reference model in order, count 20, dout stable during stalls, in_ready = !out_valid|out_ready.
REQ-036 bias_we addr 0 data 0x80 (-128) in same cycle as vector with bias_sel=0 (din all 1) -> dout=31; next vector identical -> dout=-120.
REQ-037 rst asserted with 3 vectors in flight -> no out_valid for those vectors, bias table back to reset values, next vector after release gives correct result.
